// File: rtl/proc_control_unit_pkg.sv
// Shared definitions for the 8x16-bit simple processor control path:
// opcode and time-step encodings plus instruction-register field positions.
package proc_pkg;

   localparam int IR_OP_LSB = 6;
   localparam int IR_X_LSB  = 3;
   localparam int IR_Y_LSB  = 0;

   typedef enum logic [2:0] {
      OP_MV   = 3'b000,
      OP_MVI  = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_LD   = 3'b100,
      OP_ST   = 3'b101,
      OP_MVNZ = 3'b110,
      OP_NOP  = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5
   } tstep_e;

endpackage

// File: rtl/proc_control_unit_dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all zeros when disabled.
module dec3to8 (
   input  logic [2:0] idx_i,
   input  logic       en_i,
   output logic [7:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/proc_control_unit.sv
// Fetch/execute sequencer for the simple processor: a registered time-step
// counter with every datapath strobe decoded combinationally from it.
module proc_control_unit
   import proc_pkg::*;
#(
   parameter int IR_W    = 9,
   parameter int PC_IDX  = 7,
   parameter int TSTEP_W = 3
) (
   input  logic               Clock,
   input  logic               Resetn,
   input  logic               Run,
   input  logic [IR_W-1:0]    IR,
   input  logic               Gnz,
   output logic [TSTEP_W-1:0] Tstep_Q,
   output logic               IRin,
   output logic [7:0]         Rin,
   output logic [7:0]         Rout,
   output logic               Gout,
   output logic               DINout,
   output logic               Ain,
   output logic               Gin,
   output logic               AddSub,
   output logic               ADDRin,
   output logic               DOUTin,
   output logic               W_D,
   output logic               incr_pc,
   output logic               Done
);

   localparam logic [2:0] PC_SEL = 3'(PC_IDX);

   tstep_e     tstep_q, tstep_d;
   opcode_e    op;
   logic [2:0] rx, ry;
   logic [2:0] rin_idx, rout_idx;
   logic       rin_en, rout_en;

   assign op = opcode_e'(IR[IR_OP_LSB +: 3]);
   assign rx = IR[IR_X_LSB +: 3];
   assign ry = IR[IR_Y_LSB +: 3];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) tstep_q <= T0;
      else         tstep_q <= tstep_d;
   end

   assign Tstep_Q = TSTEP_W'(tstep_q);

   // Strobes are gated by Resetn so nothing fires while reset is held, even in T0 with Run high.
   always_comb begin
      tstep_d  = T0;
      rin_idx  = rx;
      rout_idx = ry;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      IRin     = 1'b0;
      Gout     = 1'b0;
      DINout   = 1'b0;
      Ain      = 1'b0;
      Gin      = 1'b0;
      AddSub   = 1'b0;
      ADDRin   = 1'b0;
      DOUTin   = 1'b0;
      W_D      = 1'b0;
      incr_pc  = 1'b0;
      Done     = 1'b0;
      if (Resetn) begin
         unique case (tstep_q)
            T0: begin
               if (Run) begin
                  rout_idx = PC_SEL;
                  rout_en  = 1'b1;
                  ADDRin   = 1'b1;
                  incr_pc  = 1'b1;
                  tstep_d  = T1;
               end
            end
            T1: tstep_d = T2;
            T2: begin
               IRin    = 1'b1;
               tstep_d = T3;
            end
            T3: begin
               tstep_d = T4;
               unique case (op)
                  OP_MV: begin
                     rout_en = 1'b1;
                     rin_en  = 1'b1;
                     Done    = 1'b1;
                     tstep_d = T0;
                  end
                  OP_MVI: begin
                     rout_idx = PC_SEL;
                     rout_en  = 1'b1;
                     ADDRin   = 1'b1;
                     incr_pc  = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     rout_idx = rx;
                     rout_en  = 1'b1;
                     Ain      = 1'b1;
                  end
                  OP_LD, OP_ST: begin
                     rout_en = 1'b1;
                     ADDRin  = 1'b1;
                  end
                  OP_MVNZ: begin
                     rout_en = Gnz;
                     rin_en  = Gnz;
                     Done    = 1'b1;
                     tstep_d = T0;
                  end
                  OP_NOP: begin
                     Done    = 1'b1;
                     tstep_d = T0;
                  end
               endcase
            end
            T4: begin
               tstep_d = T5;
               unique case (op)
                  OP_ADD, OP_SUB: begin
                     rout_en = 1'b1;
                     Gin     = 1'b1;
                     AddSub  = (op == OP_SUB);
                  end
                  OP_ST: begin
                     rout_idx = rx;
                     rout_en  = 1'b1;
                     DOUTin   = 1'b1;
                  end
                  OP_MVI, OP_LD: ;
                  default: tstep_d = T0;
               endcase
            end
            T5: begin
               unique case (op)
                  OP_MVI, OP_LD: begin
                     DINout = 1'b1;
                     rin_en = 1'b1;
                     Done   = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     Gout   = 1'b1;
                     rin_en = 1'b1;
                     Done   = 1'b1;
                  end
                  OP_ST: begin
                     W_D  = 1'b1;
                     Done = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: tstep_d = T0;
         endcase
      end
   end

   dec3to8 u_rin_dec (
      .idx_i    (rin_idx),
      .en_i     (rin_en),
      .onehot_o (Rin)
   );

   dec3to8 u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (Rout)
   );

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: hand-written vector table for the
// documented instruction cases, reset/halt sequences, then random instructions.
module tb_proc_control_unit;

   typedef struct packed {
      logic [2:0] t;
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       gout;
      logic       dinout;
      logic       ain;
      logic       gin;
      logic       addsub;
      logic       addrin;
      logic       doutin;
      logic       wd;
      logic       incr;
      logic       done;
   } obs_t;

   typedef struct {
      string      nm;
      logic [8:0] ir;
      logic       gnz;
      int         lat;
      obs_t       e[6];
   } vec_t;

   logic       Clock = 1'b0;
   logic       Resetn, Run, Gnz;
   logic [8:0] IR;
   logic [2:0] Tstep_Q;
   logic       IRin, Gout, DINout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, incr_pc, Done;
   logic [7:0] Rin, Rout;

   int total = 0;
   int bad   = 0;

   proc_control_unit #(.IR_W(9), .PC_IDX(7), .TSTEP_W(3)) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .Run     (Run),
      .IR      (IR),
      .Gnz     (Gnz),
      .Tstep_Q (Tstep_Q),
      .IRin    (IRin),
      .Rin     (Rin),
      .Rout    (Rout),
      .Gout    (Gout),
      .DINout  (DINout),
      .Ain     (Ain),
      .Gin     (Gin),
      .AddSub  (AddSub),
      .ADDRin  (ADDRin),
      .DOUTin  (DOUTin),
      .W_D     (W_D),
      .incr_pc (incr_pc),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic obs_t zero(input logic [2:0] t);
      obs_t o;
      o   = '0;
      o.t = t;
      return o;
   endfunction

   // Reference: instruction latency from the opcode class, per-step micro-ops from the rules.
   function automatic obs_t model(input logic [8:0] ir, input logic gnz, input int k);
      obs_t       o;
      logic [2:0] op, x, y;
      int         lat;
      op  = ir[8:6];
      x   = ir[5:3];
      y   = ir[2:0];
      lat = (op == 3'd0 || op == 3'd6 || op == 3'd7) ? 4 : 6;
      o      = '0;
      o.t    = 3'(k);
      o.done = (k == lat - 1);
      if (k == 0) begin
         o.rout = 8'h80; o.addrin = 1'b1; o.incr = 1'b1;
      end else if (k == 2) begin
         o.irin = 1'b1;
      end else if (k == 3) begin
         case (op)
            3'd0: begin o.rout = 8'b1 << y; o.rin = 8'b1 << x; end
            3'd1: begin o.rout = 8'h80; o.addrin = 1'b1; o.incr = 1'b1; end
            3'd2, 3'd3: begin o.rout = 8'b1 << x; o.ain = 1'b1; end
            3'd4, 3'd5: begin o.rout = 8'b1 << y; o.addrin = 1'b1; end
            3'd6: if (gnz) begin o.rout = 8'b1 << y; o.rin = 8'b1 << x; end
            default: ;
         endcase
      end else if (k == 4) begin
         if (op == 3'd2 || op == 3'd3) begin
            o.rout = 8'b1 << y; o.gin = 1'b1; o.addsub = (op == 3'd3);
         end else if (op == 3'd5) begin
            o.rout = 8'b1 << x; o.doutin = 1'b1;
         end
      end else if (k == 5) begin
         if (op == 3'd1 || op == 3'd4) begin
            o.dinout = 1'b1; o.rin = 8'b1 << x;
         end else if (op == 3'd2 || op == 3'd3) begin
            o.gout = 1'b1; o.rin = 8'b1 << x;
         end else if (op == 3'd5) begin
            o.wd = 1'b1;
         end
      end
      return o;
   endfunction

   task automatic check(input string nm, input int k, input obs_t e);
      obs_t a;
      int   drivers;
      a = '{t: Tstep_Q, irin: IRin, rin: Rin, rout: Rout, gout: Gout, dinout: DINout,
            ain: Ain, gin: Gin, addsub: AddSub, addrin: ADDRin, doutin: DOUTin,
            wd: W_D, incr: incr_pc, done: Done};
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s k=%0d got=%h want=%h", nm, k, a, e);
      end
      drivers = $countones(Rout) + int'(Gout) + int'(DINout);
      total++;
      if (drivers > 1) begin
         bad++;
         $display("FAIL %s_bus k=%0d drivers=%0d want<=1", nm, k, drivers);
      end
   endtask

   // Entered and left just after a falling edge, with the counter at T0.
   task automatic run_vec(input vec_t v);
      for (int k = 0; k < v.lat; k++) begin
         Run = (k == 0);
         IR  = v.ir;
         Gnz = v.gnz;
         #1 check(v.nm, k, v.e[k]);
         @(negedge Clock);
      end
      Run = 1'b0;
      #1 check({v.nm, "_halt"}, 0, zero(3'd0));
      @(negedge Clock);
   endtask

   vec_t tbl[6];

   initial begin
      obs_t f[3];
      f[0] = '{t: 3'd0, rout: 8'h80, addrin: 1'b1, incr: 1'b1, default: '0};
      f[1] = '{t: 3'd1, default: '0};
      f[2] = '{t: 3'd2, irin: 1'b1, default: '0};
      foreach (tbl[i]) for (int k = 0; k < 3; k++) tbl[i].e[k] = f[k];

      tbl[0].nm = "mvi_r2";    tbl[0].ir = 9'b001_010_000; tbl[0].gnz = 1'b0; tbl[0].lat = 6;
      tbl[0].e[3] = '{t: 3'd3, rout: 8'h80, addrin: 1'b1, incr: 1'b1, default: '0};
      tbl[0].e[4] = '{t: 3'd4, default: '0};
      tbl[0].e[5] = '{t: 3'd5, dinout: 1'b1, rin: 8'h04, done: 1'b1, default: '0};

      tbl[1].nm = "sub_r1_r3"; tbl[1].ir = 9'b011_001_011; tbl[1].gnz = 1'b0; tbl[1].lat = 6;
      tbl[1].e[3] = '{t: 3'd3, rout: 8'h02, ain: 1'b1, default: '0};
      tbl[1].e[4] = '{t: 3'd4, rout: 8'h08, gin: 1'b1, addsub: 1'b1, default: '0};
      tbl[1].e[5] = '{t: 3'd5, gout: 1'b1, rin: 8'h02, done: 1'b1, default: '0};

      tbl[2].nm = "mvnz_gnz0"; tbl[2].ir = 9'b110_000_101; tbl[2].gnz = 1'b0; tbl[2].lat = 4;
      tbl[2].e[3] = '{t: 3'd3, done: 1'b1, default: '0};

      tbl[3].nm = "mvnz_gnz1"; tbl[3].ir = 9'b110_000_101; tbl[3].gnz = 1'b1; tbl[3].lat = 4;
      tbl[3].e[3] = '{t: 3'd3, rout: 8'h20, rin: 8'h01, done: 1'b1, default: '0};

      tbl[4].nm = "st_r4_r6";  tbl[4].ir = 9'b101_100_110; tbl[4].gnz = 1'b0; tbl[4].lat = 6;
      tbl[4].e[3] = '{t: 3'd3, rout: 8'h40, addrin: 1'b1, default: '0};
      tbl[4].e[4] = '{t: 3'd4, rout: 8'h10, doutin: 1'b1, default: '0};
      tbl[4].e[5] = '{t: 3'd5, wd: 1'b1, done: 1'b1, default: '0};

      tbl[5].nm = "mv_r7_r2";  tbl[5].ir = 9'b000_111_010; tbl[5].gnz = 1'b0; tbl[5].lat = 4;
      tbl[5].e[3] = '{t: 3'd3, rout: 8'h04, rin: 8'h80, done: 1'b1, default: '0};

      Resetn = 1'b0; Run = 1'b0; IR = '0; Gnz = 1'b0;
      @(negedge Clock);
      #1 check("reset", 0, zero(3'd0));
      @(negedge Clock);
      Resetn = 1'b1;

      for (int i = 0; i < 10; i++) begin
         Run = 1'b0;
         #1 check("idle", i, zero(3'd0));
         @(negedge Clock);
      end

      foreach (tbl[i]) run_vec(tbl[i]);

      // Reset asserted asynchronously in the middle of T4 of an add.
      for (int k = 0; k < 5; k++) begin
         Run = 1'b1;
         IR  = 9'b010_011_001;
         Gnz = 1'b0;
         #1 check("add_pre_rst", k, model(IR, Gnz, k));
         if (k < 4) @(negedge Clock);
      end
      #2 Resetn = 1'b0;
      #1 check("rst_async", 0, zero(3'd0));
      @(negedge Clock);
      #1 check("rst_hold", 0, zero(3'd0));
      Run = 1'b0;
      Resetn = 1'b1;
      #1 check("rst_release", 0, zero(3'd0));
      @(negedge Clock);
      #1 check("rst_release", 1, zero(3'd0));
      @(negedge Clock);

      for (int n = 0; n < 80; n++) begin
         logic [8:0] ir;
         logic [2:0] op;
         int         lat;
         int         idle;
         idle = $urandom_range(0, 2);
         for (int i = 0; i < idle; i++) begin
            Run = 1'b0;
            #1 check("rand_idle", i, zero(3'd0));
            @(negedge Clock);
         end
         ir  = 9'($urandom);
         op  = ir[8:6];
         lat = (op == 3'd0 || op == 3'd6 || op == 3'd7) ? 4 : 6;
         for (int k = 0; k < lat; k++) begin
            Run = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            Gnz = 1'($urandom_range(0, 1));
            IR  = ir;
            #1 check("rand", k, model(ir, Gnz, k));
            @(negedge Clock);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
